// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with configurable data width, parity and stop bits.
// Optional RX FIFO (first-word-fall-through) compiled in when UART_RX_FIFO_EN is defined.
module uart_core_param #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BIT_RATE      = 9600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 areset_i,
  input  logic [DATA_BITS-1:0] s_tx_data_i,
  input  logic                 s_tx_valid_i,
  output logic                 s_tx_ready_o,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_rx_data_o,
  output logic [1:0]           m_rx_err_o,
  output logic                 m_rx_valid_o,
  input  logic                 m_rx_ready_i,
  output logic                 rx_overrun_o
);
  localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // ---------------- TX ----------------
  state_e                 tx_state_q, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx_o tracks the state register.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (s_tx_valid_i) begin
          tx_state_d = ST_START;
          tx_sh_d    = s_tx_data_i;
          tx_par_d   = parity_of(s_tx_data_i);
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_d       = tx_sh_q[0];
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = 4'd0;
            tx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
            tx_d     = tx_sh_q[1];
          end
        end
      end
      ST_PAR: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_STOP;
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          tx_d     = 1'b1;
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = ST_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign s_tx_ready_o = (tx_state_q == ST_IDLE) & ~areset_i;
  assign tx_o         = tx_q;

  // ---------------- RX ----------------
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_done_s;
  logic [1:0]           rx_err_s;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // After the half-bit start check, every later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done_s  = 1'b0;
    rx_err_s   = {rx_ferr_q | ~rx_s2_q, rx_perr_q};
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) begin
          rx_state_d = ST_START;
          rx_par_d   = 1'b0;
          rx_perr_d  = 1'b0;
          rx_ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 4'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_par_d = rx_par_q ^ rx_s2_q;
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = 4'd0;
            rx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 4'd0;
          rx_perr_d  = rx_s2_q ^ rx_par_q ^ PAR_ODD;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d  = '0;
          rx_ferr_d = rx_ferr_q | ~rx_s2_q;
          if (rx_bit_q == STOP_LAST) begin
            rx_done_s  = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [DATA_BITS+1:0] mem_q [RX_FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 empty_s, full_s, pop_s, push_s, ovr_q;

  assign empty_s = (wr_q == rd_q);
  assign full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_s   = ~empty_s & m_rx_ready_i;
  assign push_s  = rx_done_s & (~full_s | pop_s);

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_q[AW-1:0]] <= {rx_err_s, rx_sh_q};
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (pop_s) rd_q <= rd_q + (AW+1)'(1);
      ovr_q <= rx_done_s & full_s & ~pop_s;
    end
  end

  assign {m_rx_err_o, m_rx_data_o} = mem_q[rd_q[AW-1:0]];
  assign m_rx_valid_o = ~empty_s;
  assign rx_overrun_o = ovr_q;
`else
  logic [DATA_BITS-1:0] out_data_q;
  logic [1:0]           out_err_q;
  logic                 out_valid_q, ovr_q;

  // A frame loads when the register is empty or being drained; otherwise it is dropped.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      out_data_q  <= '0;
      out_err_q   <= 2'b00;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (rx_done_s && (!out_valid_q || m_rx_ready_i)) begin
        out_data_q  <= rx_sh_q;
        out_err_q   <= rx_err_s;
        out_valid_q <= 1'b1;
      end else if (rx_done_s) begin
        ovr_q <= 1'b1;
      end else if (m_rx_ready_i) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
    end
  end

  assign m_rx_data_o  = out_data_q;
  assign m_rx_err_o   = out_err_q;
  assign m_rx_valid_o = out_valid_q;
  assign rx_overrun_o = ovr_q;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 8E1 instance with driven rx, 8O2 instance in loopback.
module tb_uart_core_param;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, rx_data, b_tx_data, b_rx_data;
  logic       tx_valid, tx_ready, tx, rx_drv, rx_valid, rx_ready, rx_ovr;
  logic       b_tx_valid, b_tx_ready, b_tx, b_rx_valid, b_rx_ready, b_ovr;
  logic [1:0] rx_err, b_rx_err;
  int         n_cmp = 0;
  int         n_err = 0;
  int         ovr_total = 0;
  int         ovr_base;
  int         cyc;
  logic       seen;

  always #5 clk = ~clk;

  uart_core_param #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut (
    .clk_i(clk), .areset_i(rst),
    .s_tx_data_i(tx_data), .s_tx_valid_i(tx_valid), .s_tx_ready_o(tx_ready),
    .tx_o(tx), .rx_i(rx_drv),
    .m_rx_data_o(rx_data), .m_rx_err_o(rx_err), .m_rx_valid_o(rx_valid),
    .m_rx_ready_i(rx_ready), .rx_overrun_o(rx_ovr));

  uart_core_param #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut_lb (
    .clk_i(clk), .areset_i(rst),
    .s_tx_data_i(b_tx_data), .s_tx_valid_i(b_tx_valid), .s_tx_ready_o(b_tx_ready),
    .tx_o(b_tx), .rx_i(b_tx),
    .m_rx_data_o(b_rx_data), .m_rx_err_o(b_rx_err), .m_rx_valid_o(b_rx_valid),
    .m_rx_ready_i(b_rx_ready), .rx_overrun_o(b_ovr));

  always @(negedge clk) if (rx_ovr === 1'b1) ovr_total <= ovr_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[k] is the expected line level of the k-th bit period (start .. stop).
  task automatic tx_frame(input logic [7:0] d, input logic [10:0] bits);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int c = 1; c <= 111; c++) begin
      if (c % 10 == 6) check($sformatf("tx_bit%0d", c / 10), 32'(tx), 32'(bits[c / 10]));
      if (c == 110) check("tx_ready_busy", 32'(tx_ready), 32'd0);
      if (c == 111) check("tx_ready_idle", 32'(tx_ready), 32'd1);
      if (c < 111) @(negedge clk);
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx_drv = f[b];
      repeat (10) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input string tag);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_drv = 1'b1; rx_ready = 1'b0;
    b_tx_data = 8'h00; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_err", 32'(rx_err), 32'd0);
    check("rst_ovr", 32'(rx_ovr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    tx_frame(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0});

    // Reset in the middle of bit 4 (data bit 3 of 0xA5 = 0).
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (45) @(negedge clk);
    check("mid_bit4", 32'(tx), 32'd0);
    rst = 1'b1; #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("release_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_frame(8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0});

    // Loopback 8O2: 12 bit periods, valid one cycle after the last stop sample (cycle 119).
    b_tx_data = 8'h3C; b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    cyc = 1;
    while (b_rx_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("lb_latency", 32'(cyc), 32'd119);
    check("lb_data", 32'(b_rx_data), 32'h3C);
    check("lb_err", 32'(b_rx_err), 32'd0);
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
    check("lb_popped", 32'(b_rx_valid), 32'd0);

    rx_frame(8'hC3, 1'b0, 1'b1);
    wait_rx("good");
    check("good_data", 32'(rx_data), 32'hC3);
    check("good_err", 32'(rx_err), 32'd0);
    pop_rx();
    check("good_popped", 32'(rx_valid), 32'd0);

    rx_frame(8'h01, 1'b0, 1'b1);
    wait_rx("perr");
    check("perr_data", 32'(rx_data), 32'h01);
    check("perr_err", 32'(rx_err), 32'b01);
    pop_rx();

    rx_frame(8'h55, 1'b0, 1'b0);
    wait_rx("ferr");
    check("ferr_data", 32'(rx_data), 32'h55);
    check("ferr_err", 32'(rx_err), 32'b10);
    pop_rx();
    check("ferr_popped", 32'(rx_valid), 32'd0);

    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rx_valid === 1'b1) seen = 1'b1;
    end
    check("glitch_no_valid", 32'(seen), 32'd0);
    rx_frame(8'h0F, 1'b0, 1'b1);
    wait_rx("post_glitch");
    check("post_glitch_data", 32'(rx_data), 32'h0F);
    pop_rx();

    ovr_base = ovr_total;
    rx_frame(8'h11, 1'b0, 1'b1);
    rx_frame(8'h22, 1'b0, 1'b1);
`ifdef UART_RX_FIFO_EN
    rx_frame(8'h33, 1'b0, 1'b1);
    rx_frame(8'h44, 1'b0, 1'b1);
    rx_frame(8'h55, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("fifo_ovr_pulses", 32'(ovr_total - ovr_base), 32'd1);
    check("fifo_d0", 32'(rx_data), 32'h11);
    pop_rx();
    check("fifo_d1", 32'(rx_data), 32'h22);
    pop_rx();
    check("fifo_d2", 32'(rx_data), 32'h33);
    pop_rx();
    check("fifo_d3", 32'(rx_data), 32'h44);
    check("fifo_v3", 32'(rx_valid), 32'd1);
    pop_rx();
    check("fifo_empty", 32'(rx_valid), 32'd0);
`else
    repeat (5) @(negedge clk);
    check("ovr_pulses", 32'(ovr_total - ovr_base), 32'd1);
    check("ovr_hold_data", 32'(rx_data), 32'h11);
    check("ovr_hold_valid", 32'(rx_valid), 32'd1);
    pop_rx();
    check("ovr_popped", 32'(rx_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
